// File: rtl/wave_dispatch.sv
// Waveform descriptor dispatcher: pops descriptors from the waveform FIFO and holds each for nsamp cycles.
// Optional underrun statistics are enabled with `define WAVE_DISPATCH_STATS_EN.
module wave_dispatch #(
  parameter int B     = 160,
  parameter int LEN_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  output logic         fifo_rd_en,
  input  logic [B-1:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         wave_valid,
  output logic [B-1:0] wave_data,
  output logic         wave_first,
  output logic         busy
`ifdef WAVE_DISPATCH_STATS_EN
  ,
  input  logic         stats_clr,
  output logic [15:0]  underrun_cnt
`endif
);

  // Handshake: fifo_rd_en is asserted only while fifo_empty is low; the
  // requested word is presented on fifo_dout on the following cycle, and at
  // most one read is outstanding at any time.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic             pf;
  logic             last;
  logic             near_end;
  logic             periodic;

  function automatic logic [LEN_W-1:0] hold_len(input logic [B-1:0] d);
    return (d[LEN_W-1:0] == '0) ? LEN_W'(1) : d[LEN_W-1:0];
  endfunction

  assign last     = (cnt == LEN_W'(1));
  assign near_end = (cnt == LEN_W'(2));
  assign periodic = wave_data[LEN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = FETCH;
      FETCH: state_nxt = PLAY;
      PLAY: begin
        if (last) begin
          if (pf)                        state_nxt = PLAY;
          else if (periodic && fifo_empty) state_nxt = PLAY;
          else if (!fifo_empty)          state_nxt = FETCH;
          else                           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A read in PLAY is either the prefetch (cnt==2) or the late fetch (cnt==1, no prefetch).
  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      IDLE:    fifo_rd_en = !fifo_empty;
      PLAY:    fifo_rd_en = !fifo_empty && !pf && (near_end || last);
      default: fifo_rd_en = 1'b0;
    endcase
    wave_valid = (state == PLAY);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      pf         <= 1'b0;
      wave_data  <= '0;
      wave_first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pf         <= 1'b0;
          wave_first <= 1'b0;
        end
        FETCH: begin
          wave_data  <= fifo_dout;
          cnt        <= hold_len(fifo_dout);
          wave_first <= 1'b1;
        end
        PLAY: begin
          cnt        <= cnt - LEN_W'(1);
          wave_first <= 1'b0;
          if (near_end && fifo_rd_en) pf <= 1'b1;
          if (last) begin
            if (pf) begin
              wave_data  <= fifo_dout;
              cnt        <= hold_len(fifo_dout);
              wave_first <= 1'b1;
              pf         <= 1'b0;
            end else if (periodic && fifo_empty) begin
              cnt        <= hold_len(wave_data);
              wave_first <= 1'b1;
            end
          end
        end
        default: begin
          pf         <= 1'b0;
          wave_first <= 1'b0;
        end
      endcase
    end
  end

`ifdef WAVE_DISPATCH_STATS_EN
  // Idle cycles before the first descriptor since reset are not underruns.
  logic started;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started      <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      if (wave_valid) started <= 1'b1;
      if (stats_clr) begin
        underrun_cnt <= 16'd0;
      end else if (started && !wave_valid && underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
